// File: rtl/team_08_apple_placer.sv
// team_08_apple_placer -- picks a random free grid cell for the next apple.
//
// Gathers (X_W+Y_W)/2 pairs of random bits into a candidate cell. Out-of-range
// candidates are rejected locally. In-range candidates go to the body-occupancy
// checker. Hits trigger a retry, and the first miss becomes the new apple.
// After MAX_TRIES failed tries the block gives up with place_fail. When
// TEAM_08_APPLE_SCAN_FALLBACK_EN is defined it instead scans the grid linearly
// from (0,0), and it reports grid_full if every cell is occupied.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   state[1:0]          game state: 0 IDLE, 1 RUN, 2 OVER, 3 WIN
//   rnd[1:0]            random bits from the generator
//   place_req           request a new apple (honoured only when idle and RUN)
//   chk_done, chk_hit   checker response; hit = candidate cell is occupied
//   chk_req             one-cycle pulse: check cand_x/cand_y
//   cand_x, cand_y      candidate cell, stable from chk_req until chk_done
//   apple_x, apple_y    current apple position
//   apple_valid         one-cycle pulse when the apple position is updated
//   busy                placement in progress
//   place_fail          one-cycle pulse: random tries exhausted (no scan build)
//   grid_full           one-cycle pulse: scan found no free cell (scan build)
module team_08_apple_placer #(
  parameter int X_W       = 4,
  parameter int Y_W       = 4,
  parameter int GRID_W    = 16,
  parameter int GRID_H    = 12,
  parameter int MAX_TRIES = 8,
  parameter int APPLE_X0  = 8,
  parameter int APPLE_Y0  = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [1:0]     state,
  input  logic [1:0]     rnd,
  input  logic           place_req,
  input  logic           chk_done,
  input  logic           chk_hit,
  output logic           chk_req,
  output logic [X_W-1:0] cand_x,
  output logic [Y_W-1:0] cand_y,
  output logic [X_W-1:0] apple_x,
  output logic [Y_W-1:0] apple_y,
  output logic           apple_valid,
  output logic           busy,
  output logic           place_fail,
  output logic           grid_full
);
  localparam int C_W  = X_W + Y_W;
  localparam int G_N  = C_W / 2;
  localparam int GC_W = $clog2(G_N + 1);
  localparam int T_W  = $clog2(MAX_TRIES + 1);
  localparam logic [1:0] GS_RUN = 2'd1;

  typedef enum logic [2:0] {S_IDLE, S_GATHER, S_CHECK, S_WAIT, S_DONE, S_SCAN} fsm_t;

  fsm_t            cur, nxt;
  logic [C_W-1:0]  cand;
  logic [1:0]      tick;
  logic [T_W-1:0]  tries;
  logic [GC_W-1:0] gcnt;
  logic            run, in_range, last_try, fail;

  assign cand_x   = cand[C_W-1:Y_W];
  assign cand_y   = cand[Y_W-1:0];
  assign busy     = (cur != S_IDLE);
  assign run      = (state == GS_RUN);
  assign in_range = (int'(cand_x) < GRID_W) && (int'(cand_y) < GRID_H);
  assign last_try = (int'(tries) + 1 >= MAX_TRIES);

`ifdef TEAM_08_APPLE_SCAN_FALLBACK_EN
  localparam int SC_W = $clog2(GRID_W * GRID_H + 1);
  logic            scan_mode;
  logic [SC_W-1:0] scan_cnt;
  logic [X_W-1:0]  sx;
  logic [Y_W-1:0]  sy;

  // Next scan cell: row-major walk, wrapping back to (0,0) after the last row.
  always_comb begin
    sx = cand_x + 1'b1;
    sy = cand_y;
    if (int'(cand_x) >= GRID_W - 1) begin
      sx = '0;
      sy = (int'(cand_y) >= GRID_H - 1) ? '0 : cand_y + 1'b1;
    end
  end
`endif

  always_comb begin
    nxt         = cur;
    chk_req     = 1'b0;
    apple_valid = 1'b0;
    place_fail  = 1'b0;
    grid_full   = 1'b0;
    fail        = 1'b0;
    // Leaving RUN drops any placement; a late chk_done lands in S_IDLE and is ignored.
    if (busy && !run) nxt = S_IDLE;
    else begin
      case (cur)
        S_IDLE:   if (place_req && run) nxt = S_GATHER;
        S_GATHER: if (int'(gcnt) == G_N - 1) nxt = S_CHECK;
        S_CHECK: begin
          if (in_range) begin
            chk_req = 1'b1;
            nxt     = S_WAIT;
          end else fail = 1'b1;
        end
        S_WAIT:   if (chk_done) begin
          if (chk_hit) fail = 1'b1;
          else nxt = S_DONE;
        end
        S_DONE: begin
          apple_valid = 1'b1;
          nxt         = S_IDLE;
        end
        S_SCAN:   nxt = S_CHECK;
        default:  nxt = S_IDLE;
      endcase
      if (fail) begin
`ifdef TEAM_08_APPLE_SCAN_FALLBACK_EN
        if (scan_mode) begin
          if (int'(scan_cnt) + 1 >= GRID_W * GRID_H) begin
            grid_full = 1'b1;
            nxt       = S_IDLE;
          end else nxt = S_CHECK;
        end else nxt = last_try ? S_SCAN : S_GATHER;
`else
        if (last_try) begin
          place_fail = 1'b1;
          nxt        = S_IDLE;
        end else nxt = S_GATHER;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur     <= S_IDLE;
      cand    <= '0;
      tick    <= '0;
      tries   <= '0;
      gcnt    <= '0;
      apple_x <= X_W'(APPLE_X0);
      apple_y <= Y_W'(APPLE_Y0);
`ifdef TEAM_08_APPLE_SCAN_FALLBACK_EN
      scan_mode <= 1'b0;
      scan_cnt  <= '0;
`endif
    end else begin
      cur <= nxt;
      if (cur == S_GATHER) begin
        tick <= tick + 2'd1;
        cand <= {cand[C_W-3:0], rnd ^ tick};
      end
      gcnt <= (cur == S_GATHER && nxt == S_GATHER) ? gcnt + 1'b1 : '0;
      if (cur == S_IDLE) tries <= '0;
      else if (fail && nxt == S_GATHER) tries <= tries + 1'b1;
      if (apple_valid) begin
        apple_x <= cand_x;
        apple_y <= cand_y;
      end
`ifdef TEAM_08_APPLE_SCAN_FALLBACK_EN
      if (cur == S_IDLE) scan_mode <= 1'b0;
      if (cur == S_SCAN) begin
        cand      <= '0;
        scan_mode <= 1'b1;
        scan_cnt  <= '0;
      end else if (scan_mode && fail && nxt == S_CHECK) begin
        cand     <= {sx, sy};
        scan_cnt <= scan_cnt + 1'b1;
      end
`endif
    end
  end
endmodule
